// File: rtl/decrypt_arbiter.sv
// decrypt_arbiter: round-robin frame scheduler sharing one decrypt_unit between two channels
module decrypt_arbiter #(
   parameter int LEN_W   = 8,
   parameter int DEC_LAT = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_req,
   input  logic [LEN_W-1:0] i_len0,
   input  logic [LEN_W-1:0] i_len1,
   input  logic [31:0]      i_cfg0,
   input  logic [31:0]      i_cfg1,
   input  logic [7:0]       i_din0,
   input  logic [7:0]       i_din1,
   input  logic [1:0]       i_dvalid,
   output logic [1:0]       o_rdy,
   output logic [1:0]       o_gnt,
   output logic [7:0]       o_dout,
   output logic [1:0]       o_vout,
   output logic [1:0]       o_done,
   output logic             o_dec_rst,
   output logic             o_dec_en,
   output logic [7:0]       o_dec_din,
   output logic [7:0]       o_dec_k1,
   output logic [7:0]       o_dec_k2,
   output logic [7:0]       o_dec_k3,
   output logic [2:0]       o_dec_rot_freq,
   output logic             o_dec_shift_en,
   output logic [2:0]       o_dec_shift_amt,
   output logic             o_dec_mode,
   input  logic [7:0]       i_dec_dout,
   input  logic             i_dec_v
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t           r_state, w_next;
   logic             r_g, r_last, r_dec_rst;
   logic [LEN_W-1:0] r_len, r_cnt;
   logic [31:0]      r_cfg;
   logic [3:0]       r_dr;
   logic             w_win, w_busy, w_rdy, w_dv, w_xfer;
   logic [1:0]       w_sel;
   logic [7:0]       w_din;
   assign w_win  = (&i_req) ? ~r_last : i_req[1];
   assign w_busy = r_state != S_IDLE;
   assign w_sel  = r_g ? 2'b10 : 2'b01;
   assign w_din  = r_g ? i_din1 : i_din0;
   assign w_dv   = r_g ? i_dvalid[1] : i_dvalid[0];
   assign w_rdy  = (r_state == S_RUN) && (r_cnt < r_len);
   assign w_xfer = w_rdy & w_dv;
   assign o_dec_rst = r_dec_rst;
   assign {o_dec_mode, o_dec_shift_en, o_dec_shift_amt, o_dec_rot_freq, o_dec_k1, o_dec_k2, o_dec_k3} = r_cfg;
   // state register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   // next state: drain holds DEC_LAT+1 cycles so the last result is delivered before done
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (|i_req) ? S_CLEAR : S_IDLE;
         S_CLEAR: w_next = (|r_len) ? S_RUN : S_DONE;
         S_RUN:   w_next = (w_xfer && r_cnt == r_len - 1'b1) ? S_DRAIN : S_RUN;
         S_DRAIN: w_next = (r_dr == 4'(DEC_LAT)) ? S_DONE : S_DRAIN;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   // frame context latched at grant, byte/drain counters, round-robin history, unit reset pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_g       <= 1'b0;
         r_last    <= 1'b1;
         r_len     <= '0;
         r_cfg     <= '0;
         r_cnt     <= '0;
         r_dr      <= '0;
         r_dec_rst <= 1'b0;
      end else begin
         r_dec_rst <= w_next != S_CLEAR;
         if (r_state == S_IDLE && |i_req) begin
            r_g   <= w_win;
            r_len <= w_win ? i_len1 : i_len0;
            r_cfg <= w_win ? i_cfg1 : i_cfg0;
         end
         r_cnt <= (r_state == S_CLEAR) ? '0 : r_cnt + LEN_W'(w_xfer);
         r_dr  <= (r_state == S_DRAIN) ? r_dr + 4'd1 : 4'd0;
         if (r_state == S_DONE) r_last <= r_g;
      end
   end
   // outputs steered to the owning channel only
   always_comb begin
      o_gnt     = w_busy ? w_sel : 2'b00;
      o_rdy     = w_rdy ? w_sel : 2'b00;
      o_vout    = (w_busy & i_dec_v) ? w_sel : 2'b00;
      o_done    = (r_state == S_DONE) ? w_sel : 2'b00;
      o_dec_en  = w_xfer;
      o_dec_din = (r_state == S_RUN) ? w_din : 8'h00;
      o_dout    = w_busy ? i_dec_dout : 8'h00;
   end
endmodule

// File: tb/tb_decrypt_arbiter.sv
// tb_decrypt_arbiter: randomized self-checking bench with a frame-level reference model
module tb_decrypt_arbiter;
   localparam int LEN_W = 8;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [1:0] req = '0, dvalid = '0;
   logic [LEN_W-1:0] len_a [2] = '{default: '0};
   logic [31:0] cfg_a [2] = '{default: '0};
   logic [7:0] din_a [2] = '{default: '0};
   logic [1:0] rdy, gnt, vout, done;
   logic [7:0] dout, dec_din, dec_k1, dec_k2, dec_k3, dec_dout;
   logic dec_rst, dec_en, dec_shift_en, dec_mode, dec_v;
   logic [2:0] dec_rot_freq, dec_shift_amt;
   logic [31:0] cfg_out;
   logic [7:0] s1_b = '0, s2_b = '0;
   logic s1_v = 1'b0, s2_v = 1'b0;
   int u_ph = 0, cyc = 0, checks = 0, errors = 0;
   int m_last = 1, m_owner = 0, g_cyc = 0, last_en = 0, m_sent = 0, m_len = 0;
   bit m_act = 0, m_idle_prev = 1, rnd_cfg = 0, iso = 0, use_pat = 0;
   logic [31:0] m_cfg;
   logic [1:0] req_prev;
   logic [LEN_W-1:0] len_prev [2];
   logic [31:0] cfg_prev [2];
   logic [7:0] data [2][256];
   int exp_c[$], order[$], pat[$];
   logic [7:0] exp_b[$];
   int frames_left [2] = '{0, 0};
   int p_valid = 100, n_en = 0, n_vout = 0, gnt_at = 0, done_at = 0;

   decrypt_arbiter #(.LEN_W(LEN_W), .DEC_LAT(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
      .i_len0(len_a[0]), .i_len1(len_a[1]), .i_cfg0(cfg_a[0]), .i_cfg1(cfg_a[1]),
      .i_din0(din_a[0]), .i_din1(din_a[1]), .i_dvalid(dvalid),
      .o_rdy(rdy), .o_gnt(gnt), .o_dout(dout), .o_vout(vout), .o_done(done),
      .o_dec_rst(dec_rst), .o_dec_en(dec_en), .o_dec_din(dec_din),
      .o_dec_k1(dec_k1), .o_dec_k2(dec_k2), .o_dec_k3(dec_k3), .o_dec_rot_freq(dec_rot_freq),
      .o_dec_shift_en(dec_shift_en), .o_dec_shift_amt(dec_shift_amt), .o_dec_mode(dec_mode),
      .i_dec_dout(dec_dout), .i_dec_v(dec_v)
   );

   assign cfg_out = {dec_mode, dec_shift_en, dec_shift_amt, dec_rot_freq, dec_k1, dec_k2, dec_k3};
   assign dec_dout = s2_b;
   assign dec_v = s2_v;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // stand-in decrypt transform: key picked by phase/rot_freq, optional rotate and invert
   function automatic logic [7:0] f(input logic [7:0] b, input int ph, input logic [31:0] c);
      int per;
      logic [7:0] k, x;
      per = int'(c[26:24]) + 1;
      case ((ph / per) % 3)
         0: k = c[23:16];
         1: k = c[15:8];
         default: k = c[7:0];
      endcase
      x = b ^ k;
      if (c[30]) x = (x << c[29:27]) | (x >> (4'd8 - {1'b0, c[29:27]}));
      if (c[31]) x = ~x;
      return x;
   endfunction

   // behavioural decrypt_unit: two-stage pipeline, key phase cleared by dec_rst
   always @(posedge clk) begin
      if (!dec_rst) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_b <= '0; s2_b <= '0; u_ph <= 0;
      end else begin
         s1_v <= dec_en; s1_b <= f(dec_din, u_ph, cfg_out);
         if (dec_en) u_ph <= u_ph + 1;
         s2_v <= s1_v; s2_b <= s1_b;
      end
   end

   // drives both channels and scores every cycle against the frame-level model
   task automatic run_frames(input int max_cyc);
      int k;
      bit fin, exp_rdy, exp_en, exp_done;
      logic [1:0] oh, prev_gnt;
      fin = 0; prev_gnt = 0; order.delete(); exp_c.delete(); exp_b.delete();
      n_en = 0; n_vout = 0; gnt_at = -1; done_at = -1;
      m_act = 0; m_idle_prev = 1; req_prev = 0; len_prev = len_a; cfg_prev = cfg_a;
      for (int n = 0; n < max_cyc && !fin; n++) begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            req[c] = frames_left[c] > 0;
            if (rnd_cfg) begin len_a[c] = LEN_W'($urandom_range(0, 10)); cfg_a[c] = $urandom; end
            if (m_act && m_owner == c) begin
               k = cyc - g_cyc - 1;
               dvalid[c] = use_pat ? (k < 0 || k >= pat.size() || pat[k] != 0) : ($urandom_range(0, 99) < p_valid);
               din_a[c] = data[c][m_sent & 255];
            end else begin
               dvalid[c] = iso ? 1'b1 : 1'($urandom_range(0, 1));
               din_a[c] = iso ? 8'hAA : 8'($urandom);
            end
         end
         #1;
         if (!m_act && m_idle_prev && req_prev != 2'b00) begin
            m_owner = (req_prev == 2'b11) ? 1 - m_last : (req_prev[1] ? 1 : 0);
            m_act = 1; g_cyc = cyc; m_len = int'(len_prev[m_owner]); m_cfg = cfg_prev[m_owner]; m_sent = 0;
            for (int i = 0; i < 256; i++) data[m_owner][i] = 8'($urandom);
         end
         oh = m_act ? 2'(1 << m_owner) : 2'b00;
         if (gnt != 0 && prev_gnt == 0) begin gnt_at = cyc; order.push_back(gnt[1] ? 1 : 0); end
         prev_gnt = gnt;
         if (done != 0) done_at = cyc;
         if (dec_en) n_en++;
         if (vout != 0) n_vout++;
         checks++; if (gnt !== oh) begin errors++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, oh); end
         checks++; if (dec_rst !== !(m_act && cyc == g_cyc)) begin errors++; $display("FAIL dec_rst cyc=%0d got=%b", cyc, dec_rst); end
         exp_rdy = m_act && cyc > g_cyc && m_sent < m_len;
         checks++; if (rdy !== (exp_rdy ? oh : 2'b00)) begin errors++; $display("FAIL rdy cyc=%0d got=%b exp=%b", cyc, rdy, exp_rdy ? oh : 2'b00); end
         exp_en = exp_rdy && dvalid[m_owner];
         checks++; if (dec_en !== exp_en) begin errors++; $display("FAIL dec_en cyc=%0d got=%b exp=%b", cyc, dec_en, exp_en); end
         if (m_act) begin
            checks++; if (cfg_out !== m_cfg) begin errors++; $display("FAIL cfg cyc=%0d got=%h exp=%h", cyc, cfg_out, m_cfg); end
         end
         if (exp_en) begin
            checks++; if (dec_din !== data[m_owner][m_sent]) begin errors++; $display("FAIL dec_din cyc=%0d got=%h exp=%h", cyc, dec_din, data[m_owner][m_sent]); end
            exp_c.push_back(cyc + 2); exp_b.push_back(f(data[m_owner][m_sent], m_sent, m_cfg));
            m_sent++; last_en = cyc;
         end
         if (exp_c.size() > 0 && exp_c[0] == cyc) begin
            checks++; if (vout !== oh || dout !== exp_b[0]) begin errors++; $display("FAIL vout cyc=%0d got=%b/%h exp=%b/%h", cyc, vout, dout, oh, exp_b[0]); end
            void'(exp_c.pop_front()); void'(exp_b.pop_front());
         end else begin
            checks++; if (vout !== 2'b00) begin errors++; $display("FAIL vout_idle cyc=%0d got=%b exp=00", cyc, vout); end
         end
         exp_done = m_act && m_sent == m_len && cyc == (m_len == 0 ? g_cyc + 1 : last_en + 4);
         checks++; if (done !== (exp_done ? oh : 2'b00)) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done ? oh : 2'b00); end
         m_idle_prev = !m_act;
         if (exp_done) begin m_act = 0; m_last = m_owner; frames_left[m_owner]--; end
         req_prev = req; len_prev = len_a; cfg_prev = cfg_a;
         fin = frames_left[0] == 0 && frames_left[1] == 0 && !m_act && exp_c.size() == 0;
      end
      checks++; if (!fin) begin errors++; $display("FAIL timeout got=running exp=all frames done"); end
      @(negedge clk); req = 2'b00; dvalid = 2'b00; frames_left = '{0, 0};
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (gnt !== 0 || rdy !== 0) begin errors++; $display("FAIL reset_gnt_rdy got=%b/%b exp=00/00", gnt, rdy); end
      checks++; if (vout !== 0 || done !== 0) begin errors++; $display("FAIL reset_vout_done got=%b/%b exp=00/00", vout, done); end
      checks++; if (dec_en !== 0 || dec_rst !== 0) begin errors++; $display("FAIL reset_dec got=%b/%b exp=0/0", dec_en, dec_rst); end
      checks++; if (dout !== 0 || dec_din !== 0 || cfg_out !== 0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", dout, dec_din, cfg_out); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (dec_rst !== 1'b1 || gnt !== 0) begin errors++; $display("FAIL reset_release got=%b/%b exp=1/00", dec_rst, gnt); end
   endtask

   task automatic test_contention;
      rnd_cfg = 0; iso = 0; use_pat = 0; p_valid = 100;
      len_a = '{8'd2, 8'd2}; cfg_a[0] = $urandom; cfg_a[1] = $urandom;
      frames_left = '{2, 2};
      run_frames(300);
      checks++; if (order.size() != 4) begin errors++; $display("FAIL contention_count got=%0d exp=4", order.size()); end
      for (int i = 0; i < order.size() && i < 4; i++) begin
         checks++; if (order[i] != i % 2) begin errors++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, order[i], i % 2); end
      end
   endtask

   task automatic test_single;
      rnd_cfg = 0; iso = 0; use_pat = 0; p_valid = 100;
      len_a[0] = 8'd3; cfg_a[0] = 32'h0011_2233; frames_left = '{1, 0};
      run_frames(100);
      checks++; if (done_at - gnt_at != 7) begin errors++; $display("FAIL single_latency got=%0d exp=7", done_at - gnt_at); end
      checks++; if (n_en != 3 || n_vout != 3) begin errors++; $display("FAIL single_counts got=%0d/%0d exp=3/3", n_en, n_vout); end
   endtask

   task automatic test_zero_len;
      rnd_cfg = 0; iso = 0; use_pat = 0;
      len_a[1] = 8'd0; cfg_a[1] = $urandom; frames_left = '{0, 1};
      run_frames(50);
      checks++; if (n_en != 0 || n_vout != 0) begin errors++; $display("FAIL zero_len_activity got=%0d/%0d exp=0/0", n_en, n_vout); end
      checks++; if (done_at - gnt_at != 1 || order.size() != 1 || order[0] != 1) begin errors++; $display("FAIL zero_len_frame got=%0d exp=1", done_at - gnt_at); end
   endtask

   task automatic test_stall;
      rnd_cfg = 0; iso = 0; use_pat = 1; pat = '{1, 0, 0, 1, 1, 0, 1};
      len_a[0] = 8'd4; cfg_a[0] = $urandom; frames_left = '{1, 0};
      run_frames(100);
      use_pat = 0;
      checks++; if (n_en != 4 || n_vout != 4) begin errors++; $display("FAIL stall_counts got=%0d/%0d exp=4/4", n_en, n_vout); end
      checks++; if (done_at - gnt_at != 11) begin errors++; $display("FAIL stall_latency got=%0d exp=11", done_at - gnt_at); end
   endtask

   task automatic test_isolation;
      rnd_cfg = 0; iso = 1; use_pat = 0; p_valid = 100;
      len_a[0] = 8'd6; cfg_a[0] = $urandom; frames_left = '{1, 0};
      run_frames(100);
      iso = 0;
      checks++; if (n_en != 6 || n_vout != 6 || order.size() != 1 || order[0] != 0) begin errors++; $display("FAIL isolation got=%0d/%0d exp=6/6", n_en, n_vout); end
   endtask

   task automatic test_back_to_back;
      rnd_cfg = 1; iso = 0; use_pat = 0; p_valid = 70;
      frames_left = '{3, 3};
      run_frames(2000);
      checks++; if (order.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", order.size()); end
      for (int i = 1; i < order.size(); i++) begin
         checks++; if (order[i] == order[i-1]) begin errors++; $display("FAIL b2b_alternate idx=%0d got=%0d exp=%0d", i, order[i], 1 - order[i-1]); end
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         rnd_cfg = 1; iso = $urandom_range(0, 1) == 1; use_pat = 0; p_valid = $urandom_range(30, 100);
         frames_left = '{$urandom_range(1, 3), $urandom_range(0, 3)};
         run_frames(3000);
         checks++; if (n_vout != n_en) begin errors++; $display("FAIL random_results round=%0d got=%0d exp=%0d", r, n_vout, n_en); end
      end
      iso = 0;
   endtask

   task automatic test_mid_reset;
      int seen;
      seen = 0; rnd_cfg = 0;
      len_a[0] = 8'd5; cfg_a[0] = $urandom;
      @(negedge clk); req = 2'b01; dvalid = 2'b01; din_a[0] = 8'h5A;
      for (int n = 0; n < 40 && seen < 2; n++) begin @(negedge clk); #1; if (dec_en) seen++; end
      checks++; if (seen != 2) begin errors++; $display("FAIL midrst_setup got=%0d exp=2", seen); end
      @(negedge clk); rst_n = 1'b0; req = 2'b00; dvalid = 2'b00;
      #1;
      checks++; if (gnt !== 0 || rdy !== 0 || vout !== 0 || done !== 0) begin errors++; $display("FAIL midrst_ctrl got=%b/%b/%b/%b exp=0", gnt, rdy, vout, done); end
      checks++; if (dec_en !== 0 || dec_rst !== 0 || dout !== 0 || dec_din !== 0 || cfg_out !== 0) begin errors++; $display("FAIL midrst_dec got=%b/%b/%h/%h/%h exp=0", dec_en, dec_rst, dout, dec_din, cfg_out); end
      repeat (2) begin
         @(negedge clk); #1;
         checks++; if (dec_rst !== 0 || gnt !== 0) begin errors++; $display("FAIL midrst_hold got=%b/%b exp=0/00", dec_rst, gnt); end
      end
      @(negedge clk); rst_n = 1'b1;
      m_last = 1; len_a = '{8'd2, 8'd3}; frames_left = '{1, 1};
      run_frames(300);
      checks++; if (order.size() != 2 || order[0] != 0) begin errors++; $display("FAIL midrst_priority got=%0d exp=0", order.size() > 0 ? order[0] : -1); end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_zero_len();
      test_stall();
      test_isolation();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
endmodule
